// File: rtl/axa_pkg.sv
// Shared AXA definitions: ISA opcodes, execute-unit state encoding and the default datapath width.
package axa_pkg;

  localparam int unsigned AXA_WIDTH = 16;
  localparam int unsigned OP_W      = 6;

  // Processor OP field encoding; anything not handled by the execute unit reports err.
  localparam logic [OP_W-1:0] OPsys    = 6'h00;
  localparam logic [OP_W-1:0] OPcom    = 6'h01;
  localparam logic [OP_W-1:0] OPadd    = 6'h02;
  localparam logic [OP_W-1:0] OPsub    = 6'h03;
  localparam logic [OP_W-1:0] OPxor    = 6'h04;
  localparam logic [OP_W-1:0] OPex     = 6'h05;
  localparam logic [OP_W-1:0] OProl    = 6'h06;
  localparam logic [OP_W-1:0] OPshr    = 6'h07;
  localparam logic [OP_W-1:0] OPor     = 6'h08;
  localparam logic [OP_W-1:0] OPand    = 6'h09;
  localparam logic [OP_W-1:0] OPdup    = 6'h0A;
  localparam logic [OP_W-1:0] OPland   = 6'h0B;
  localparam logic [OP_W-1:0] OPbeq    = 6'h10;
  localparam logic [OP_W-1:0] OPbne    = 6'h11;
  localparam logic [OP_W-1:0] OPjmp    = 6'h12;
  localparam logic [OP_W-1:0] OPjsr    = 6'h13;
  localparam logic [OP_W-1:0] OPjerr   = 6'h14;
  localparam logic [OP_W-1:0] OPfail   = 6'h15;
  localparam logic [OP_W-1:0] OPaddi8  = 6'h20;
  localparam logic [OP_W-1:0] OPsubi8  = 6'h21;
  localparam logic [OP_W-1:0] OPandi8  = 6'h22;
  localparam logic [OP_W-1:0] OPori8   = 6'h23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  typedef enum logic {
    DIR_ROL = 1'b0,
    DIR_SHR = 1'b1
  } shift_dir_e;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OProl) || (op == OPshr);
  endfunction

endpackage

// File: rtl/axa_shift_iter.sv
// Iterative rotate-left / logical-shift-right engine: moves one bit position per cycle
// while its down-counter is non-zero.
module axa_shift_iter
  import axa_pkg::*;
#(
  parameter int unsigned WIDTH = AXA_WIDTH,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  shift_dir_e       i_dir,
  input  logic [CNTW-1:0]  i_count,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_busy_c,
  output logic             o_last_c,
  output logic [WIDTH-1:0] o_value_c
);

  logic [WIDTH-1:0] r_val;
  logic [CNTW-1:0]  r_cnt;
  shift_dir_e       r_dir;
  logic [WIDTH-1:0] w_step;

  assign w_step    = (r_dir == DIR_ROL) ? {r_val[WIDTH-2:0], r_val[WIDTH-1]}
                                        : {1'b0, r_val[WIDTH-1:1]};
  assign o_busy_c  = (r_cnt != '0);
  assign o_last_c  = (r_cnt == CNTW'(1));
  // Value as it will be after this cycle's move, so the final result can be captured on the last step.
  assign o_value_c = o_busy_c ? w_step : r_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_val <= '0;
      r_cnt <= '0;
      r_dir <= DIR_ROL;
    end else if (i_load) begin
      r_val <= i_value;
      r_cnt <= i_count;
      r_dir <= i_dir;
    end else if (o_busy_c) begin
      r_val <= w_step;
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/axa_seq_alu.sv
// AXA multi-cycle execute unit: start/ready/done handshake, single-cycle logic/arithmetic ops,
// iterative rotate/shift, result flags and illegal-op reporting.
module axa_seq_alu
  import axa_pkg::*;
#(
  parameter int unsigned WIDTH = AXA_WIDTH,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  alu_state_e       r_state;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_neg;
  logic             r_err;

  logic [WIDTH-1:0] w_result;
  logic             w_err;
  logic             w_shift;
  logic [CNTW-1:0]  w_cnt;
  shift_dir_e       w_dir;
  logic             w_load;
  logic             w_last;
  logic             w_busy;
  logic [WIDTH-1:0] w_shift_val;

  assign w_cnt  = in2[CNTW-1:0];
  assign w_dir  = (op == OPshr) ? DIR_SHR : DIR_ROL;
  assign w_load = (r_state == ST_IDLE) && start && w_shift && (w_cnt != '0);

  // Single-cycle result; rotate/shift by zero degenerates to passing in1 through.
  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    w_shift  = 1'b0;
    case (op)
      OPadd:  w_result = in1 + in2;
      OPsub:  w_result = in1 - in2;
      OPxor:  w_result = in1 ^ in2;
      OPor:   w_result = in1 | in2;
      OPand:  w_result = in1 & in2;
      OPex:   w_result = in2;
      OPdup:  w_result = in1;
      OPland: w_result = WIDTH'((in1 != '0) && (in2 != '0));
      OProl, OPshr: begin
        w_shift  = 1'b1;
        w_result = in1;
      end
      default: w_err = 1'b1;
    endcase
  end

  axa_shift_iter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_dir     (w_dir),
    .i_count   (w_cnt),
    .i_value   (in1),
    .o_busy_c  (w_busy),
    .o_last_c  (w_last),
    .o_value_c (w_shift_val)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b1;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ready <= 1'b0;
            if (w_load) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_out   <= w_result;
              r_zero  <= (w_result == '0);
              r_neg   <= w_result[WIDTH-1];
              r_err   <= w_err;
            end
          end
        end
        ST_SHIFT: begin
          if (w_last && w_busy) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_out   <= w_shift_val;
            r_zero  <= (w_shift_val == '0);
            r_neg   <= w_shift_val[WIDTH-1];
            r_err   <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign out   = r_out;
  assign zero  = r_zero;
  assign neg   = r_neg;
  assign err   = r_err;

endmodule

// File: tb/tb_axa_seq_alu.sv
// Directed bench for axa_seq_alu (WIDTH=16): expected results are queued at issue and checked at done.
module tb_axa_seq_alu;
  import axa_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         ready;
  logic         done;
  logic [W-1:0] out;
  logic         zero;
  logic         neg;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  // {out, zero, neg, err}
  logic [W+2:0] sb_q[$];

  axa_seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .ready (ready),
    .done  (done),
    .out   (out),
    .zero  (zero),
    .neg   (neg),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [5:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic [2*W-1:0] dbl;
    logic           e;
    int             c;
    r = '0;
    e = 1'b0;
    c = int'(b[3:0]);
    case (o)
      OPadd:  r = W'(a + b);
      OPsub:  r = W'(a - b);
      OPxor:  r = a ^ b;
      OPor:   r = a | b;
      OPand:  r = a & b;
      OPex:   r = b;
      OPdup:  r = a;
      OPland: r = (a != 0 && b != 0) ? 16'h0001 : 16'h0000;
      OProl: begin
        dbl = {a, a} << c;
        r   = dbl[2*W-1:W];
      end
      OPshr:  r = a >> c;
      default: e = 1'b1;
    endcase
    return {r, (r == 0), r[W-1], e};
  endfunction

  // Issue one op at a negedge (cycle N) and follow it to done; optionally pulse start while busy.
  task automatic run_op(input string tag, input logic [5:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic pulse);
    int           lat;
    int           exp_lat;
    logic [W+2:0] e;
    exp_lat = ((o == OProl || o == OPshr) && b[3:0] != 0) ? 1 + int'(b[3:0]) : 1;
    chk({tag, "_ready_pre"}, 32'(ready), 32'd1);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    lat   = 1;
    start = pulse;
    in1   = W'($urandom);
    in2   = W'($urandom);
    op    = 6'($urandom);
    while (done !== 1'b1 && lat < 40) begin
      chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ready_in_done"}, 32'(ready), 32'd0);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_out"},  32'(out),  32'(e[W+2:3]));
      chk({tag, "_zero"}, 32'(zero), 32'(e[2]));
      chk({tag, "_neg"},  32'(neg),  32'(e[1]));
      chk({tag, "_err"},  32'(err),  32'(e[0]));
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_post"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int seen_done;
    reset = 1'b0;
    start = 1'b0;
    op    = '0;
    in1   = '0;
    in2   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_out",   32'(out),   32'd0);
    chk("rst_zero",  32'(zero),  32'd1);
    chk("rst_neg",   32'(neg),   32'd0);
    chk("rst_err",   32'(err),   32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("add",      OPadd,  16'h7FFF, 16'h0001, 1'b0);
    run_op("sub",      OPsub,  16'h0005, 16'h0005, 1'b0);
    run_op("land0",    OPland, 16'h0003, 16'h0000, 1'b0);
    run_op("land1",    OPland, 16'h0003, 16'h0100, 1'b0);
    run_op("rol3",     OProl,  16'h8001, 16'h0013, 1'b0);
    run_op("shr15",    OPshr,  16'h8000, 16'h000F, 1'b0);
    run_op("rol0",     OProl,  16'hA5C3, 16'h0010, 1'b0);
    run_op("rol5_pls", OProl,  16'h1234, 16'h0005, 1'b1);
    run_op("shr4_pls", OPshr,  16'hF00F, 16'h0004, 1'b1);
    run_op("or",       OPor,   16'h1200, 16'h0034, 1'b0);
    run_op("and",      OPand,  16'hFF0F, 16'h0FF0, 1'b0);
    run_op("ex",       OPex,   16'h1111, 16'h9ABC, 1'b0);
    run_op("dup",      OPdup,  16'h8642, 16'h0000, 1'b0);
    run_op("illegal",  6'h3F,  16'h1234, 16'h5678, 1'b0);
    run_op("jerr",     OPjerr, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("xor",      OPxor,  16'hF0F0, 16'h0FF0, 1'b0);

    // Reset in the middle of a rotate by 8 must abort it without a done pulse.
    start = 1'b1;
    op    = OProl;
    in1   = 16'h1234;
    in2   = 16'h0008;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy", 32'(ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_out",   32'(out),   32'd0);
    chk("abort_zero",  32'(zero),  32'd1);
    chk("abort_neg",   32'(neg),   32'd0);
    chk("abort_done",  32'(done),  32'd0);
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    run_op("post_rst", OPadd, 16'hFFFF, 16'h0001, 1'b0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axa_seq_alu.md
Name: axa_seq_alu

Overview:
- Parametrised multi-cycle execute unit for the AXA processor. It replaces the old combinational ALU.
- Operations use a start/ready/done handshake. Rotate and shift are iterative, one bit position per cycle.
- Sits between the processor's operand-fetch states (register / I4 / I8 / memory source) and register writeback.
- Adds result flags and illegal-op reporting.

Parameters:
- WIDTH, 16: datapath width in bits; must be a power of two, at least 4.
- CNTW, $clog2(WIDTH): shift-count width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request a new operation; sampled only while ready=1.
- op  in  6  AXA opcode, same encoding as the processor OP field.
- in1  in  WIDTH  destination-register operand.
- in2  in  WIDTH  source operand (register, immediate, or memory).
- ready  out  1  unit idle and able to accept start.
- done  out  1  one-cycle pulse; result and flags valid.
- out  out  WIDTH  result; held until the next done.
- zero  out  1  out==0, registered with out.
- neg  out  1  out[WIDTH-1], registered with out.
- err  out  1  op not supported; valid with done, held until the next done.

Behaviour:
- Reset (reset==0 at a rising clk edge): state=IDLE, ready=1, done=0, out=0, zero=1, neg=0, err=0. Reset overrides start. Reset aborts any operation in progress with no done pulse; the unit is idle the following cycle.
- States are IDLE, SHIFT and DONE. ready=1 only in IDLE. DONE lasts exactly one cycle, then returns to IDLE.
- Accept: if start=1 and ready=1 in cycle N, latch op, in1 and in2. start while ready=0 is ignored and never queued.
- Single-cycle ops: result registered at the end of cycle N. State goes IDLE->DONE, so done=1 in cycle N+1 and ready=1 in N+2.
  - add: in1+in2.
  - sub: in1-in2.
  - xor: in1^in2.
  - or: in1|in2.
  - and: in1&in2.
  - ex: out=in2.
  - dup: out=in1.
  - land: out = (in1!=0 && in2!=0) ? 1 : 0.
- Arithmetic wraps modulo 2^WIDTH. Carry and borrow are discarded.
- Iterative ops:
  - rol: rotate left by c = in2[CNTW-1:0]; upper in2 bits are ignored.
  - shr: logical shift right by c, zero fill.
  - If c=0: IDLE->DONE; done at N+1 with out=in1.
  - Otherwise: IDLE->SHIFT. A counter loaded with c decrements once per SHIFT cycle, with one bit position moved per cycle. The last SHIFT cycle moves to DONE, so done=1 at cycle N+1+c.
- Any other op (sys, com, branch/jump ops, jerr, fail, 8-bit immediate ops, unassigned codes): IDLE->DONE with err=1 and out=0 (zero=1, neg=0).
- err=0 for every supported op.
- zero and neg always reflect the value of out presented with done.
- out, zero, neg and err change only in the DONE cycle or on reset.
- The in1, in2 and op inputs may change freely after acceptance; latched copies are used throughout.

Decomposition:
- Shared package axa_pkg holds:
  - The 6-bit opcode constants (OPadd, OPsub, OPxor, OPex, OProl, OPshr, OPor, OPand, OPdup, OPland, and the remaining ISA codes).
  - The state encodings for this unit.
  - The default data width of 16.
- One natural sub-module: axa_shift_iter.
  - Holds the shift register and the down-counter.
  - Interface: load, dir (rol/shr), count, busy, last, value.
  - Instanced once inside axa_seq_alu.

Test Plan (WIDTH=16):
1. add, in1=0x7FFF, in2=0x0001, start at N -> done at N+1, out=0x8000, neg=1, zero=0, err=0; ready=1 at N+2.
2. sub, in1=0x0005, in2=0x0005 -> done at N+1, out=0x0000, zero=1. Then land 0x0003, 0x0000 -> out=0x0000; land 0x0003, 0x0100 -> out=0x0001.
3. rol, in1=0x8001, in2=0x0013 (c=3) -> ready=0 during N+1..N+3, done at N+4, out=0x000C. shr, in1=0x8000, in2=0x000F -> done at N+16, out=0x0001.
4. rol with in2=0x0010 (c=0) -> done at N+1, out=in1. start pulsed during SHIFT cycles is ignored: exactly one done, and the result is unaffected.
5. op=6'b111111 -> done at N+1, err=1, out=0. The next valid op (xor 0xF0F0, 0x0FF0 -> 0xFF00) clears err.
6. reset=0 at N+2 during rol with c=8 -> N+3: ready=1, out=0, zero=1; no done pulse at N+9 or later.
